// File: rtl/scan_pkg.sv
// Shared types and elaboration helpers for the blocked/raster result-address sequencer.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  typedef enum logic {
    BLOCKED = 1'b0,
    RASTER  = 1'b1
  } scan_mode_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/blocked_scan_addr_gen_wrap_counter.sv
// Wrapping up-counter whose terminal value is chosen at runtime (bounded by MAX).
module wrap_counter
  import scan_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // MAX is a hard ceiling so a bad runtime term can never run the count past it.
  assign wrap  = (count_q == term) || (count_q == W'(MAX));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/blocked_scan_addr_gen.sv
// Emits every image index once, in blocked (partition/block/row/column) or raster order,
// over a valid/ready output; addr is the sum of registered bases, no multipliers.
module blocked_scan_addr_gen
  import scan_pkg::*;
#(
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_PX     = 2,
  parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic                  addr_ready,
  output logic                  addr_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam int PX_WIDTH = ROW_SIZE / NUM_PX;
  localparam int NUM_XB   = ceil_div(PX_WIDTH, BLOCKING);
  localparam int LAST_XI  = PX_WIDTH - (NUM_XB - 1) * BLOCKING;
  // xi doubles as the column counter in raster mode, so it must reach ROW_SIZE-1.
  localparam int XI_MAX   = ((ROW_SIZE > BLOCKING) ? ROW_SIZE : BLOCKING) - 1;
  localparam int XI_W     = cnt_width(XI_MAX);
  localparam int Y_W      = cnt_width(COL_SIZE - 1);
  localparam int X_W      = cnt_width(NUM_XB - 1);
  localparam int P_W      = cnt_width(NUM_PX - 1);

  if (ROW_SIZE % NUM_PX != 0) begin : g_bad_params
    $error("blocked_scan_addr_gen: ROW_SIZE must be a multiple of NUM_PX");
  end

  // Handshake: a transfer happens on a rising edge where addr_valid & addr_ready;
  // while valid is high and ready low, addr/last hold and valid stays up
  // (only abort or reset can withdraw it).
  scan_state_e state_q, state_d;
  scan_mode_e  mode_q, mode_d;

  logic [ADDR_WIDTH-1:0] px_base_q, px_base_d;
  logic [ADDR_WIDTH-1:0] xb_base_q, xb_base_d;
  logic [ADDR_WIDTH-1:0] row_off_q, row_off_d;

  logic [XI_W-1:0] xi_cnt, xi_term;
  logic [Y_W-1:0]  y_cnt;
  logic [X_W-1:0]  x_cnt;
  logic [P_W-1:0]  px_cnt;
  logic            xi_wrap, y_wrap, x_wrap, px_wrap;

  logic hs, clr, step, last_int;
  logic y_inc, x_inc, px_inc;

  assign xi_term  = (mode_q == RASTER) ? XI_W'(ROW_SIZE - 1)
                  : (x_wrap ? XI_W'(LAST_XI - 1) : XI_W'(BLOCKING - 1));
  assign last_int = xi_wrap & y_wrap & ((mode_q == RASTER) | (x_wrap & px_wrap));
  assign hs       = (state_q == RUN) & addr_ready;

  assign y_inc  = step & xi_wrap;
  assign x_inc  = y_inc & y_wrap & (mode_q == BLOCKED);
  assign px_inc = x_inc & x_wrap;

  wrap_counter #(.MAX(XI_MAX), .W(XI_W)) u_xi (
    .clk(wb_clk_i), .rst(wb_rst_i), .inc(step), .clr(clr),
    .term(xi_term), .count(xi_cnt), .wrap(xi_wrap)
  );

  wrap_counter #(.MAX(COL_SIZE - 1), .W(Y_W)) u_y (
    .clk(wb_clk_i), .rst(wb_rst_i), .inc(y_inc), .clr(clr),
    .term(Y_W'(COL_SIZE - 1)), .count(y_cnt), .wrap(y_wrap)
  );

  wrap_counter #(.MAX(NUM_XB - 1), .W(X_W)) u_x (
    .clk(wb_clk_i), .rst(wb_rst_i), .inc(x_inc), .clr(clr),
    .term(X_W'(NUM_XB - 1)), .count(x_cnt), .wrap(x_wrap)
  );

  wrap_counter #(.MAX(NUM_PX - 1), .W(P_W)) u_px (
    .clk(wb_clk_i), .rst(wb_rst_i), .inc(px_inc), .clr(clr),
    .term(P_W'(NUM_PX - 1)), .count(px_cnt), .wrap(px_wrap)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    clr     = 1'b0;
    step    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            state_d = RUN;
            mode_d  = scan_mode_e'(mode);
            clr     = 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            if (last_int) begin
              state_d = DONE;
              clr     = 1'b1;
            end else begin
              step = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bases advance in lock-step with the counter that owns them and fall back to 0 on wrap.
  always_comb begin
    px_base_d = px_base_q;
    xb_base_d = xb_base_q;
    row_off_d = row_off_q;
    if (clr) begin
      px_base_d = '0;
      xb_base_d = '0;
      row_off_d = '0;
    end else begin
      if (y_inc)  row_off_d = y_wrap ? '0 : row_off_q + ADDR_WIDTH'(ROW_SIZE);
      if (x_inc)  xb_base_d = x_wrap ? '0 : xb_base_q + ADDR_WIDTH'(BLOCKING);
      if (px_inc) px_base_d = px_base_q + ADDR_WIDTH'(PX_WIDTH);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      mode_q    <= BLOCKED;
      px_base_q <= '0;
      xb_base_q <= '0;
      row_off_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      px_base_q <= px_base_d;
      xb_base_q <= xb_base_d;
      row_off_q <= row_off_d;
    end
  end

  // Every output is a function of flops only; counters are zero whenever not in RUN.
  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign last       = (state_q == RUN) & last_int;
  assign addr       = px_base_q + xb_base_q + row_off_q + ADDR_WIDTH'(xi_cnt);

endmodule

// File: tb/tb_blocked_scan_addr_gen.sv
// Randomised scoreboard bench: a default-size and a 16x3 instance checked against a loop-nest model.
module tb_blocked_scan_addr_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic start0, mode0, abort0, ready0, valid0, last0, busy0, done0;
  logic start1, mode1, abort1, ready1, valid1, last1, busy1, done1;
  logic [8:0] addr0;
  logic [5:0] addr1;

  blocked_scan_addr_gen u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start0), .mode(mode0), .abort(abort0),
    .addr_ready(ready0), .addr_valid(valid0), .addr(addr0), .last(last0),
    .busy(busy0), .done(done0)
  );

  blocked_scan_addr_gen #(.ROW_SIZE(16), .COL_SIZE(3), .BLOCKING(4), .NUM_PX(2)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start1), .mode(mode1), .abort(abort1),
    .addr_ready(ready1), .addr_valid(valid1), .addr(addr1), .last(last1),
    .busy(busy1), .done(done1)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt[2];
  bit done_seen[2];
  bit exp_done[2];
  bit stall_prev[2];
  logic [15:0] stall_val[2];
  bit chk_en = 1'b1;
  int rdy_mode[2];
  int stall_left = 0;
  bit stalled100 = 1'b0;
  int cap0[494];
  int cap1[48];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic geo(input int g, output int rs, output int cs, output int bl, output int npx);
    if (g == 0) begin rs = 26; cs = 19; bl = 4; npx = 2; end
    else        begin rs = 16; cs = 3;  bl = 4; npx = 2; end
  endtask

  task automatic model_push(input int g, input bit raster);
    int rs, cs, bl, npx, pw, nxb, lxi, n, w;
    int seq[$];
    logic [15:0] e;
    geo(g, rs, cs, bl, npx);
    n   = rs * cs;
    pw  = rs / npx;
    nxb = (pw + bl - 1) / bl;
    lxi = pw - (nxb - 1) * bl;
    if (raster) begin
      for (int i = 0; i < n; i++) seq.push_back(i);
    end else begin
      for (int p = 0; p < npx; p++)
        for (int x = 0; x < nxb; x++) begin
          w = (x == nxb - 1) ? lxi : bl;
          for (int y = 0; y < cs; y++)
            for (int xi = 0; xi < w; xi++)
              seq.push_back(p * pw + y * rs + x * bl + xi);
        end
    end
    foreach (seq[i]) begin
      e = 16'(seq[i]);
      e[15] = (i == n - 1);
      if (g == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_step(input int g, input logic v, input logic r, input logic [15:0] a,
                          input logic l, input logic d, input logic b, input logic ab);
    logic [15:0] e;
    logic [15:0] obs;
    int qs;
    if (!chk_en) return;
    obs = {l, a[14:0]};
    chk($sformatf("done%0d", g), int'(d), int'(exp_done[g]));
    if (exp_done[g]) chk($sformatf("valid_after_last%0d", g), int'(v), 0);
    if (d) done_seen[g] = 1'b1;
    exp_done[g] = 1'b0;
    chk($sformatf("busy%0d", g), int'(b), int'(v));
    if (stall_prev[g]) begin
      chk($sformatf("stall_valid%0d", g), int'(v), 1);
      chk($sformatf("stall_hold%0d", g), int'(obs), int'(stall_val[g]));
    end
    stall_prev[g] = 1'b0;
    if (v && !ab) begin
      if (r) begin
        qs = (g == 0) ? exp_q0.size() : exp_q1.size();
        if (qs == 0) begin
          chk($sformatf("unexpected_hs%0d", g), int'(obs), -1);
        end else begin
          e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("addr_last%0d[%0d]", g, hs_cnt[g]), int'(obs), int'(e));
          if (g == 0 && hs_cnt[0] < 494) cap0[hs_cnt[0]] = int'(a);
          if (g == 1 && hs_cnt[1] < 48)  cap1[hs_cnt[1]] = int'(a);
          hs_cnt[g]++;
          if (e[15]) exp_done[g] = 1'b1;
        end
      end else begin
        stall_prev[g] = 1'b1;
        stall_val[g]  = obs;
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, valid0, ready0, {7'd0, addr0}, last0, done0, busy0, abort0);
    mon_step(1, valid1, ready1, {10'd0, addr1}, last1, done1, busy1, abort1);
  end

  // ---------------- ready driver ----------------
  task automatic next_ready(input int g, output logic r);
    case (rdy_mode[g])
      0: r = 1'b1;
      1: r = ($urandom_range(0, 3) != 0);
      2: begin
        if (!stalled100 && hs_cnt[g] >= 100) begin
          stalled100 = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          stall_left--;
          r = 1'b0;
        end else begin
          r = stalled100 ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
      default: r = 1'b0;
    endcase
  endtask

  always begin
    @(posedge clk);
    #1;
    next_ready(0, ready0);
    next_ready(1, ready1);
  end

  // ---------------- stimulus tasks ----------------
  task automatic set_start(input int g, input logic s, input logic m);
    if (g == 0) begin start0 = s; mode0 = m; end
    else        begin start1 = s; mode1 = m; end
  endtask

  task automatic flush(input int g);
    if (g == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic run_scan(input int g, input bit raster, input int rmode, input bit poke);
    bit poked;
    poked = 1'b0;
    rdy_mode[g] = rmode;
    hs_cnt[g] = 0;
    done_seen[g] = 1'b0;
    model_push(g, raster);
    @(posedge clk); #1; set_start(g, 1'b1, raster);
    @(posedge clk); #1; set_start(g, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk($sformatf("first_valid%0d", g), int'(g == 0 ? valid0 : valid1), 1);
    chk($sformatf("first_busy%0d", g), int'(g == 0 ? busy0 : busy1), 1);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk); #1;
      if (done_seen[g]) break;
      if (poke && !poked && hs_cnt[g] >= 30) begin
        poked = 1'b1;
        @(posedge clk); #1; set_start(g, 1'b1, ~raster);
        @(posedge clk); #1; set_start(g, 1'b0, 1'b0);
      end
    end
    chk($sformatf("scan_done_seen%0d", g), int'(done_seen[g]), 1);
    chk($sformatf("queue_left%0d", g), (g == 0) ? exp_q0.size() : exp_q1.size(), 0);
    flush(g);
    @(negedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int first1[13];
    bit seen[494];
    int uniq;
    first1 = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35, 4};
    rst = 1'b1;
    start0 = 0; mode0 = 0; abort0 = 0;
    start1 = 0; mode1 = 0; abort1 = 0;
    rdy_mode[0] = 0; rdy_mode[1] = 0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", int'(valid0), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_last", int'(last0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Default geometry, blocked order, always ready.
    run_scan(0, 1'b0, 0, 1'b0);
    chk("blk_count", hs_cnt[0], 494);
    chk("blk_idx0", cap0[0], 0);
    chk("blk_idx1", cap0[1], 1);
    chk("blk_idx2", cap0[2], 2);
    chk("blk_idx3", cap0[3], 3);
    chk("blk_idx4", cap0[4], 26);
    chk("blk_idx76", cap0[76], 4);
    chk("blk_x3_a", cap0[228], 12);
    chk("blk_x3_b", cap0[229], 38);
    chk("blk_x3_c", cap0[230], 64);
    chk("blk_final", cap0[493], 493);
    uniq = 0;
    foreach (cap0[i]) if (cap0[i] >= 0 && cap0[i] < 494 && !seen[cap0[i]]) begin
      seen[cap0[i]] = 1'b1;
      uniq++;
    end
    chk("blk_permutation", uniq, 494);

    run_scan(0, 1'b1, 0, 1'b0);
    chk("raster_count", hs_cnt[0], 494);

    run_scan(0, 1'b0, 2, 1'b0);
    chk("bp_count", hs_cnt[0], 494);

    run_scan(1, 1'b0, 0, 1'b0);
    foreach (first1[i]) chk($sformatf("small_idx%0d", i), cap1[i], first1[i]);
    chk("small_final", cap1[47], 47);

    run_scan(1, 1'b1, 1, 1'b0);
    run_scan(0, 1'b0, 1, 1'b1);

    // Abort around index 50: no done pulse, then a clean restart.
    rdy_mode[0] = 0;
    hs_cnt[0] = 0;
    model_push(0, 1'b0);
    @(posedge clk); #1; set_start(0, 1'b1, 1'b0);
    @(posedge clk); #1; set_start(0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk); #1;
      if (hs_cnt[0] >= 50) break;
    end
    chk("abort_reach50", int'(hs_cnt[0] >= 50), 1);
    rdy_mode[0] = 3;
    @(posedge clk); #2; abort0 = 1'b1;
    @(posedge clk); #2; abort0 = 1'b0;
    @(negedge clk); #1;
    chk("abort_valid", int'(valid0), 0);
    chk("abort_busy", int'(busy0), 0);
    repeat (3) @(negedge clk);
    flush(0);
    run_scan(0, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a scan.
    rdy_mode[0] = 1;
    hs_cnt[0] = 0;
    model_push(0, 1'b1);
    @(posedge clk); #1; set_start(0, 1'b1, 1'b1);
    @(posedge clk); #1; set_start(0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk); #1;
      if (hs_cnt[0] >= 40) break;
    end
    chk_en = 1'b0;
    @(posedge clk); #3; rst = 1'b1;
    #1;
    chk("arst_valid", int'(valid0), 0);
    chk("arst_addr", int'(addr0), 0);
    chk("arst_last", int'(last0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_done", int'(done0), 0);
    #10;
    flush(0);
    @(posedge clk); #3; rst = 1'b0;
    stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
    exp_done[0] = 1'b0;   exp_done[1] = 1'b0;
    chk_en = 1'b1;
    run_scan(0, 1'b1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blocked_scan_addr_gen.md
# blocked_scan_addr_gen

Parametrised address sequencer for the accelerator's result path. It emits the raster-image query index of every result in the order the core streams results out. That order is column-partition, then block-column, then row, then in-block column, with a short final block when the partition width is not a multiple of `BLOCKING`. A raster mode is also selectable. It sits beside the output FIFO in the top wrapper and tags each dequeued index with its image address, replacing the fixed 26×19 / 4-block ordering hard-coded in host software.

## Interface
Parameters:
- `ROW_SIZE`, 26: image row length in patches
- `COL_SIZE`, 19: number of rows
- `BLOCKING`, 4: block-column width
- `NUM_PX`, 2: column partitions; `ROW_SIZE % NUM_PX == 0` is required (elaboration `$error` otherwise)
- `ADDR_WIDTH`, `$clog2(ROW_SIZE*COL_SIZE)`: address width

Derived localparams:
- `PX_WIDTH = ROW_SIZE/NUM_PX`
- `NUM_XB = ceil(PX_WIDTH/BLOCKING)`
- `LAST_XI = PX_WIDTH-(NUM_XB-1)*BLOCKING` (range 1..BLOCKING)

Ports (one clock; reset is asynchronous and active-high, ports `wb_clk_i` / `wb_rst_i`):
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  async active-high reset
- `start`  in  1  one-cycle request to begin a scan
- `mode`  in  1  0 = blocked order, 1 = raster order; sampled on accepted `start`
- `abort`  in  1  terminate the scan; return to IDLE
- `addr_ready`  in  1  consumer accepts `addr`
- `addr_valid`  out  1  `addr` is valid
- `addr`  out  ADDR_WIDTH  image index
- `last`  out  1  qualifies the final address of the scan
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE, then `start` → RUN; latch `mode`; load the first address 0.
- RUN: on handshake (`addr_valid & addr_ready`), advance to the next address. On handshake with `last=1`, go to DONE.
- DONE lasts one cycle (`done=1`), then IDLE. A `start` in DONE is accepted and goes directly to RUN.
- `start` in RUN is ignored.
- `abort` in any state: go to IDLE next cycle with no `done` pulse. `abort` has priority over `start` and over the handshake.
- Blocked order uses nested counters `px` (0..NUM_PX-1), `x` (0..NUM_XB-1), `y` (0..COL_SIZE-1), `xi`:
  - `xi` runs 0..BLOCKING-1, or 0..LAST_XI-1 when `x == NUM_XB-1`.
  - `addr = px*PX_WIDTH + y*ROW_SIZE + x*BLOCKING + xi`.
  - `xi` is innermost and `px` is outermost.
- Raster order: `addr` runs 0..ROW_SIZE*COL_SIZE-1.
- Arithmetic: no multipliers. Keep registered bases `px_base` (+PX_WIDTH), `xb_base` (+BLOCKING) and `row_off` (+ROW_SIZE), all ADDR_WIDTH bits wide; `addr` is their sum with `xi`. The maximum sum is ROW_SIZE*COL_SIZE-1, so it never overflows.
- `last` is asserted for the terminal address only: all counters at their maxima (blocked order), or N-1 (raster order).
- Total addresses per scan = ROW_SIZE*COL_SIZE in both modes. Each address appears exactly once.

## Timing
- Reset values: state IDLE; `addr_valid`, `addr`, `last`, `busy`, `done` = 0; all counters and bases 0.
- Outputs are registered.
- `start` at edge t: `addr_valid=1`, `addr=0`, `busy=1` from t+1.
- Throughput is one address per cycle while `addr_ready` is held high.
- When `addr_valid=1` and `addr_ready=0`, `addr` and `last` hold stable and `addr_valid` stays high. Valid never drops without a handshake, except on abort or reset.
- Final handshake at edge t: at t+1 `addr_valid=0`, `busy=0`, `done=1`. At t+2 `done=0`.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously).

## Structure
- Package `scan_pkg`:
  - `scan_state_e` (IDLE/RUN/DONE)
  - `scan_mode_e` (BLOCKED=0, RASTER=1)
  - function `ceil_div` for NUM_XB
- Sub-module `wrap_counter`: parameter `MAX`, inputs `inc` and `clr`, outputs `count` and a `wrap` flag; the terminal value is selectable at runtime for the `xi` short block. Instantiate it for `xi`, `y`, `x` and `px`.

## Test plan
- Default params, blocked order, `addr_ready`=1:
  - the first 5 addresses are 0,1,2,3,26;
  - the address at index 76 is 4;
  - the x=3 block yields 12,38,64,…;
  - the last address is 493 with `last=1`;
  - exactly 494 addresses, a permutation of 0..493;
  - `done` pulses 1 cycle after the final handshake.
- Raster mode: sequence 0..493, `last` only on 493.
- Backpressure: `addr_ready` driven low for 5 cycles at index 100 and randomly thereafter → `addr` stable and `addr_valid` high throughout; the sequence is identical to the no-stall run.
- Parameters ROW_SIZE=16, COL_SIZE=3, BLOCKING=4, NUM_PX=2 (LAST_XI=4):
  - the first 13 addresses are 0,1,2,3,16,17,18,19,32,33,34,35,4;
  - the last address is 47.
- `start` pulsed during RUN → ignored, sequence unaffected.
- `abort` at index 50 → IDLE next cycle, no `done`; a following `start` restarts at 0.
- Asynchronous `wb_rst_i` mid-scan → outputs 0 immediately.
